// File: rtl/systolic_n_body_pkg.sv
// Shared types for the systolic n-body pipeline: accumulator FSM states and the
// operand bundle handed from the acceleration accumulator to the integrator.
package systolic_n_body_pkg;

    typedef enum logic {
        ACCUM,
        EMIT
    } state_t;

    localparam int N_BODIES_DEFAULT = 2;

    typedef struct {
        real q_told;
        real q_t;
        real a_t;
        real dt;
    } nbody_operands_t;

endpackage

// File: rtl/systolic_n_body_accel_accum.sv
// Sums the pairwise acceleration stream for one body (self term dropped) and
// presents the integrator's operand set as a single valid/ready transaction.
module systolic_n_body_accel_accum
    import systolic_n_body_pkg::*;
#(
    parameter int N_BODIES = N_BODIES_DEFAULT,
    parameter int IDX_W    = (N_BODIES > 1) ? $clog2(N_BODIES) : 1,
    parameter int STEP_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  real               in_a_ij,
    input  real               in_q_i_told,
    input  real               in_q_i_t,
    input  real               in_dt,
    output logic              out_valid,
    input  logic              out_ready,
    output real               out_q_i_told,
    output real               out_q_i_t,
    output real               out_a_t,
    output real               out_dt,
    output logic [IDX_W-1:0]  out_body,
    output logic [STEP_W-1:0] out_step
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BODIES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] body_idx;
    logic [IDX_W-1:0] beat_idx;
    real              acc;
    real              acc_nxt;
    real              q_told_hold;
    real              q_t_hold;
    logic             accept;
    logic             transfer;
    logic             last_beat;
    logic             first_beat;

    assign accept     = in_valid && in_ready;
    assign transfer   = out_valid && out_ready;
    assign last_beat  = (beat_idx == LAST_IDX);
    assign first_beat = (beat_idx == '0);
    assign out_body   = body_idx;

    // The self term is excluded by mux rather than by adding zero, so a NaN or
    // Inf on the j == i beat can never reach the running sum.
    always_comb begin
        acc_nxt = acc;
        if (beat_idx != body_idx) begin
            acc_nxt = acc + in_a_ij;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last_beat) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: begin
                state_nxt = ACCUM;
            end
        endcase
    end

    // Outputs are latched on the last beat so the presented set stays frozen
    // for the whole EMIT phase regardless of what the source drives.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc          <= 0.0;
            q_told_hold  <= 0.0;
            q_t_hold     <= 0.0;
            beat_idx     <= '0;
            body_idx     <= '0;
            out_step     <= '0;
            out_q_i_told <= 0.0;
            out_q_i_t    <= 0.0;
            out_a_t      <= 0.0;
            out_dt       <= 0.0;
        end else begin
            if (accept) begin
                acc <= acc_nxt;
                if (first_beat) begin
                    q_told_hold <= in_q_i_told;
                    q_t_hold    <= in_q_i_t;
                end
                if (last_beat) begin
                    out_a_t      <= acc_nxt;
                    out_dt       <= in_dt;
                    out_q_i_told <= first_beat ? in_q_i_told : q_told_hold;
                    out_q_i_t    <= first_beat ? in_q_i_t : q_t_hold;
                end else begin
                    beat_idx <= beat_idx + IDX_W'(1);
                end
            end
            if (transfer) begin
                acc      <= 0.0;
                beat_idx <= '0;
                if (body_idx == LAST_IDX) begin
                    body_idx <= '0;
                    out_step <= out_step + STEP_W'(1);
                end else begin
                    body_idx <= body_idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_n_body_accel_accum.sv
// Bench for the acceleration accumulator: table vectors, hand-written corner
// sequences and a randomized run against a sum-of-non-self-terms model.
module tb_systolic_n_body_accel_accum;
    import systolic_n_body_pkg::*;

    localparam int STEP_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              in_valid;
    logic              in_ready;
    real               in_a_ij;
    real               in_q_i_told;
    real               in_q_i_t;
    real               in_dt;
    logic              out_valid;
    logic              out_ready;
    real               out_q_i_told;
    real               out_q_i_t;
    real               out_a_t;
    real               out_dt;
    logic [0:0]        out_body;
    logic [STEP_W-1:0] out_step;

    logic              in_valid_3;
    logic              in_ready_3;
    real               in_a_ij_3;
    real               in_q_i_told_3;
    real               in_q_i_t_3;
    real               in_dt_3;
    logic              out_valid_3;
    logic              out_ready_3;
    real               out_q_i_told_3;
    real               out_q_i_t_3;
    real               out_a_t_3;
    real               out_dt_3;
    logic [1:0]        out_body_3;
    logic [STEP_W-1:0] out_step_3;

    systolic_n_body_accel_accum #(.N_BODIES(2), .STEP_W(STEP_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a_ij(in_a_ij),
        .in_q_i_told(in_q_i_told), .in_q_i_t(in_q_i_t), .in_dt(in_dt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q_i_told(out_q_i_told), .out_q_i_t(out_q_i_t),
        .out_a_t(out_a_t), .out_dt(out_dt),
        .out_body(out_body), .out_step(out_step)
    );

    systolic_n_body_accel_accum #(.N_BODIES(3), .STEP_W(STEP_W)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_3), .in_ready(in_ready_3), .in_a_ij(in_a_ij_3),
        .in_q_i_told(in_q_i_told_3), .in_q_i_t(in_q_i_t_3), .in_dt(in_dt_3),
        .out_valid(out_valid_3), .out_ready(out_ready_3),
        .out_q_i_told(out_q_i_told_3), .out_q_i_t(out_q_i_t_3),
        .out_a_t(out_a_t_3), .out_dt(out_dt_3),
        .out_body(out_body_3), .out_step(out_step_3)
    );

    typedef struct {
        nbody_operands_t ops;
        real             a0;
        real             a1;
        int              exp_body;
        int              exp_step;
        int              next_body;
        int              next_step;
        bit              chain;
    } vec_t;

    vec_t vecs [4];
    int   checks = 0;
    int   errors = 0;
    int   mi;
    int   mstep;
    real  nan_v;
    real  inf_v;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReal(input string name, input real act, input real exp);
        checks++;
        if (!(act == exp || ((act - exp) < 1.0e-9 && (exp - act) < 1.0e-9))) begin
            errors++;
            $display("[TB] FAIL %s: got %g, expected %g", name, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drives both beats of one body for the N=2 instance; q and dt carry junk on
    // beats where they must not be sampled.
    task automatic applyStimulus(input real a0, input real a1, input real qo, input real qt,
                                 input real dt, input bit early, input bit stalls);
        out_ready = early;
        for (int j = 0; j < 2; j++) begin
            if (stalls) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_a_ij  = 777.0;
                    tick();
                end
            end
            in_valid    = 1'b1;
            in_a_ij     = (j == 0) ? a0 : a1;
            in_q_i_told = (j == 0) ? qo : -55.0;
            in_q_i_t    = (j == 0) ? qt : -66.0;
            in_dt       = (j == 1) ? dt : -0.5;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input nbody_operands_t e, input int eb, input int es);
        checkInt({tag, " out_valid"}, int'(out_valid), 1);
        checkInt({tag, " in_ready"}, int'(in_ready), 0);
        checkReal({tag, " out_a_t"}, out_a_t, e.a_t);
        checkReal({tag, " out_q_i_told"}, out_q_i_told, e.q_told);
        checkReal({tag, " out_q_i_t"}, out_q_i_t, e.q_t);
        checkReal({tag, " out_dt"}, out_dt, e.dt);
        checkInt({tag, " out_body"}, int'(out_body), eb);
        checkInt({tag, " out_step"}, int'(out_step), es);
    endtask

    // Holds EMIT with a competing beat on the input, then completes the transfer.
    task automatic completeTransfer(input string tag, input int hold, input real ea,
                                    input int nb, input int ns);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_a_ij   = 99.0;
            tick();
            checkInt({tag, " hold out_valid"}, int'(out_valid), 1);
            checkInt({tag, " hold in_ready"}, int'(in_ready), 0);
            checkReal({tag, " hold out_a_t"}, out_a_t, ea);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkInt({tag, " post out_valid"}, int'(out_valid), 0);
        checkInt({tag, " post in_ready"}, int'(in_ready), 1);
        checkInt({tag, " post out_body"}, int'(out_body), nb);
        checkInt({tag, " post out_step"}, int'(out_step), ns);
    endtask

    task automatic beat3(input real a, input real qo, input real qt, input real dt);
        in_valid_3    = 1'b1;
        in_a_ij_3     = a;
        in_q_i_told_3 = qo;
        in_q_i_t_3    = qt;
        in_dt_3       = dt;
        tick();
        in_valid_3 = 1'b0;
    endtask

    function automatic real modelSum(input real a0, input real a1, input int body);
        real terms [2];
        real s;
        terms[0] = a0;
        terms[1] = a1;
        s = 0.0;
        for (int j = 0; j < 2; j++) begin
            if (j != body) s = s + terms[j];
        end
        return s;
    endfunction

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nbody_operands_t e;
        real a0;
        real a1;
        real qnew;
        bit  early;
        int  hold;

        nan_v = $bitstoreal(64'h7FF8000000000000);
        inf_v = $bitstoreal(64'h7FF0000000000000);

        vecs[0] = '{'{1.5, 4.0, 1.0, 0.1}, 5.0, 1.0, 0, 0, 1, 0, 1'b1};
        vecs[1] = '{'{0.5, 0.75, 2.5, 0.2}, 2.5, 7.0, 1, 0, 0, 1, 1'b0};
        vecs[2] = '{'{2.0, -1.0, 0.25, 0.05}, -3.0, 0.25, 0, 1, 1, 1, 1'b0};
        vecs[3] = '{'{3.0, 3.5, 1000.0, 0.01}, 1000.0, -8.0, 1, 1, 0, 2, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0; in_a_ij = 0.0; in_q_i_told = 0.0; in_q_i_t = 0.0; in_dt = 0.0;
        out_ready = 1'b0;
        in_valid_3 = 1'b0; in_a_ij_3 = 0.0; in_q_i_told_3 = 0.0; in_q_i_t_3 = 0.0; in_dt_3 = 0.0;
        out_ready_3 = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        checkInt("reset in_ready", int'(in_ready), 1);
        checkInt("reset out_valid", int'(out_valid), 0);
        checkReal("reset out_a_t", out_a_t, 0.0);
        checkReal("reset out_q_i_told", out_q_i_told, 0.0);
        checkReal("reset out_dt", out_dt, 0.0);
        checkInt("reset out_body", int'(out_body), 0);
        checkInt("reset out_step", int'(out_step), 0);

        for (int k = 0; k < 4; k++) begin
            applyStimulus(vecs[k].a0, vecs[k].a1, vecs[k].ops.q_told, vecs[k].ops.q_t,
                          vecs[k].ops.dt, 1'b0, 1'b0);
            checkOutput($sformatf("vec%0d", k), vecs[k].ops, vecs[k].exp_body, vecs[k].exp_step);
            if (vecs[k].chain) begin
                qnew = 2.0 * out_q_i_t - out_q_i_told + out_a_t * out_dt * out_dt;
                checkReal($sformatf("vec%0d chained q_new", k), qnew, 6.51);
            end
            completeTransfer($sformatf("vec%0d", k), k, vecs[k].ops.a_t,
                             vecs[k].next_body, vecs[k].next_step);
        end

        in_valid = 1'b1; in_a_ij = 4.0; in_q_i_told = 9.0; in_q_i_t = 9.0; in_dt = 9.0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        checkInt("midreset in_ready", int'(in_ready), 1);
        checkInt("midreset out_valid", int'(out_valid), 0);
        checkReal("midreset out_a_t", out_a_t, 0.0);
        checkReal("midreset out_q_i_t", out_q_i_t, 0.0);
        checkInt("midreset out_body", int'(out_body), 0);
        checkInt("midreset out_step", int'(out_step), 0);
        applyStimulus(0.0, 3.0, 1.0, 2.0, 0.3, 1'b0, 1'b0);
        e = '{1.0, 2.0, 3.0, 0.3};
        checkOutput("after reset", e, 0, 0);
        completeTransfer("after reset", 1, 3.0, 1, 0);

        mi = 1;
        mstep = 0;
        for (int r = 0; r < 40; r++) begin
            a0 = real'(int'($urandom_range(0, 4000)) - 2000) / 16.0;
            a1 = real'(int'($urandom_range(0, 4000)) - 2000) / 16.0;
            if ($urandom_range(0, 3) == 0) begin
                if (mi == 0) a0 = ($urandom_range(0, 1) == 0) ? nan_v : inf_v;
                else         a1 = ($urandom_range(0, 1) == 0) ? nan_v : inf_v;
            end
            e.q_told = real'(int'($urandom_range(0, 1000))) / 4.0;
            e.q_t    = real'(int'($urandom_range(0, 1000))) / 4.0;
            e.dt     = real'(int'($urandom_range(1, 64))) / 128.0;
            e.a_t    = modelSum(a0, a1, mi);
            early    = 1'($urandom_range(0, 1));
            hold     = early ? 0 : int'($urandom_range(0, 2));
            applyStimulus(a0, a1, e.q_told, e.q_t, e.dt, early, 1'b1);
            checkOutput($sformatf("rand%0d", r), e, mi, mstep);
            if (mi == 1) mstep = (mstep + 1) % 65536;
            mi = (mi + 1) % 2;
            completeTransfer($sformatf("rand%0d", r), hold, e.a_t, mi, mstep);
        end

        beat3(4.0, 1.25, 2.25, 9.0);
        beat3(1.0, -7.0, -7.0, 9.0);
        beat3(2.0, -7.0, -7.0, 0.5);
        checkInt("n3 body0 out_valid", int'(out_valid_3), 1);
        checkReal("n3 body0 out_a_t", out_a_t_3, 3.0);
        checkReal("n3 body0 out_q_i_told", out_q_i_told_3, 1.25);
        checkReal("n3 body0 out_dt", out_dt_3, 0.5);
        out_ready_3 = 1'b1;
        tick();
        out_ready_3 = 1'b0;
        checkInt("n3 body after transfer", int'(out_body_3), 1);
        beat3(1.0, 0.5, 0.75, 9.0);
        beat3(nan_v, 8.0, 8.0, 9.0);
        beat3(2.0, 8.0, 8.0, 0.125);
        checkInt("n3 nan out_valid", int'(out_valid_3), 1);
        checkReal("n3 nan out_a_t", out_a_t_3, 3.0);
        checkReal("n3 nan out_q_i_t", out_q_i_t_3, 0.75);
        checkInt("n3 nan out_body", int'(out_body_3), 1);
        out_ready_3 = 1'b1;
        tick();
        out_ready_3 = 1'b0;
        checkInt("n3 final out_body", int'(out_body_3), 2);
        checkInt("n3 final out_step", int'(out_step_3), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
